// File: rtl/seven_scanner.sv
// seven_scanner: time-multiplexed driver for an 8-digit common-anode
// seven-segment display.
//
// Each digit owns a slot of DIGIT_CYCLES clocks. The first BLANK_CYCLES of
// every slot keep all anodes and cathodes off so the previous digit's pattern
// cannot ghost onto the next one. Segment and enable inputs are sampled once
// per frame, at the end of the frame_start cycle, so a display never tears
// mid-frame.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   segments     8 x 8 cathode patterns, active-low, bit 7 = DP, [0] = rightmost
//   digit_enable per-digit enable, 0 keeps the digit dark
//   an           anode drive, active-low, at most one bit low
//   ca           shared cathode drive, active-low
//   frame_start  one-cycle pulse on the first cycle of slot 0
module seven_scanner #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0][7:0] segments,
    input  logic [7:0]      digit_enable,
    output logic [7:0]      an,
    output logic [7:0]      ca,
    output logic            frame_start
);

    localparam int CW = $clog2(DIGIT_CYCLES);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    // Cleared by reset; the first edge after release starts a fresh frame at
    // idx 0 / cnt 0 instead of advancing the counter.
    logic            running;
    logic            slot_end;
    logic [7:0][7:0] snap_seg, snap_seg_nxt;
    logic [7:0]      snap_en, snap_en_nxt;
    logic [7:0]      an_nxt, ca_nxt;
    logic            fs_nxt;

    // Position of the next cycle. Outputs are registered from these so that
    // the registered an/ca/frame_start line up with the registered idx/cnt.
    always_comb begin
        slot_end = running && (cnt == CW'(DIGIT_CYCLES - 1));
        cnt_nxt  = (!running || slot_end) ? '0 : cnt + CW'(1);
        idx_nxt  = slot_end ? idx + 3'd1 : idx;
    end

    // Snapshot as it will stand during the next cycle.
    always_comb begin
        snap_seg_nxt = snap_seg;
        snap_en_nxt  = snap_en;
        if (frame_start) begin
            snap_seg_nxt = segments;
            snap_en_nxt  = digit_enable;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= BLANK;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        an_nxt    = 8'hFF;
        ca_nxt    = 8'hFF;
        fs_nxt    = (idx_nxt == 3'd0) && (cnt_nxt == '0);
        case (state)
            BLANK: if (running && cnt_nxt == CW'(BLANK_CYCLES)) state_nxt = DRIVE;
            DRIVE: if (slot_end) state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase
        if (state_nxt == DRIVE && snap_en_nxt[idx_nxt]) begin
            an_nxt[idx_nxt] = 1'b0;
            ca_nxt          = snap_seg_nxt[idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running     <= 1'b0;
            idx         <= 3'd0;
            cnt         <= '0;
            snap_seg    <= {8{8'hFF}};
            snap_en     <= 8'h00;
            an          <= 8'hFF;
            ca          <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            running     <= 1'b1;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            snap_seg    <= snap_seg_nxt;
            snap_en     <= snap_en_nxt;
            an          <= an_nxt;
            ca          <= ca_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule
